// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs,
// runs data-memory reads/writes over a req/ack handshake to a memory whose
// latency varies, holds the upstream pipeline while an access is
// outstanding, and produces the registered MEM/WB bundle.
//
// Parameters
//   TIMEOUT : BUSY cycles without ack before the access is aborted (0 = never)
//   CNT_W   : width of the timeout counter (TIMEOUT < 2**CNT_W)
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   IALUResult            : address for loads/stores, or ALU result
//   IMemWrData            : store data
//   IWriteReg, ICRegWrite : destination register / write enable
//   ICMemtoReg            : write-back select (passed through)
//   ICMemRead, ICMemWrite : load / store (both set = store)
//   mem_req/we/addr/wdata : request to data memory, held stable until ack
//   mem_ack, mem_rdata    : 1-cycle completion pulse and read data
//   stall                 : combinational hold for upstream stages
//   mem_fault             : 1-cycle pulse on misalignment or timeout
//   O*                    : registered MEM/WB bundle
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IALUResult,
    input  logic [31:0] IMemWrData,
    input  logic [4:0]  IWriteReg,
    input  logic        ICRegWrite,
    input  logic [1:0]  ICMemtoReg,
    input  logic        ICMemRead,
    input  logic        ICMemWrite,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        mem_fault,
    output logic [31:0] OALUResult,
    output logic [31:0] OMemData,
    output logic [4:0]  OWriteReg,
    output logic        OCRegWrite,
    output logic [1:0]  OCMemtoReg
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Value of the counter in the last BUSY cycle before an abort. Only
    // meaningful when TIMEOUT != 0; the guard in timeout_hit covers 0.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;

    logic access;
    logic aligned;
    logic timeout_hit;

    assign access      = ICMemRead | ICMemWrite;
    assign aligned     = (IALUResult[1:0] == 2'b00);
    assign timeout_hit = (TIMEOUT != 0) && (counter == TO_LAST) && !mem_ack;

    // Stall never looks at mem_rdata, so there is no path from memory data
    // back into the upstream pipeline.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access & aligned;
            BUSY:    stall = !mem_ack && !timeout_hit;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_fault  <= 1'b0;
            OALUResult <= '0;
            OMemData   <= '0;
            OWriteReg  <= '0;
            OCRegWrite <= 1'b0;
            OCMemtoReg <= '0;
        end else begin
            mem_fault  <= 1'b0;
            // The upstream stage is held by stall, so latching the inputs
            // every cycle is harmless; bubbles are made by clearing
            // OCRegWrite.
            OALUResult <= IALUResult;
            OWriteReg  <= IWriteReg;
            OCMemtoReg <= ICMemtoReg;
            OMemData   <= '0;
            case (state)
                IDLE: begin
                    if (!access) begin
                        OCRegWrite <= ICRegWrite;
                    end else if (aligned) begin
                        state      <= BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= ICMemWrite;
                        mem_addr   <= IALUResult;
                        mem_wdata  <= IMemWrData;
                        counter    <= '0;
                        OCRegWrite <= 1'b0;
                    end else begin
                        mem_fault  <= 1'b1;
                        OCRegWrite <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        OMemData   <= mem_we ? 32'd0 : mem_rdata;
                        OCRegWrite <= ICRegWrite;
                    end else if (timeout_hit) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_fault  <= 1'b1;
                        OCRegWrite <= 1'b0;
                    end else begin
                        counter    <= counter + CNT_W'(1);
                        OCRegWrite <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_req    <= 1'b0;
                    OCRegWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit with TIMEOUT=4. A table of single-cycle
// IDLE vectors (ALU pass-through and misaligned accesses) is applied in a
// loop; hand-written sequences cover loads, stores, timeout, stray acks and
// reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [31:0] IALUResult;
    logic [31:0] IMemWrData;
    logic [4:0]  IWriteReg;
    logic        ICRegWrite;
    logic [1:0]  ICMemtoReg;
    logic        ICMemRead;
    logic        ICMemWrite;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        mem_fault;
    logic [31:0] OALUResult;
    logic [31:0] OMemData;
    logic [4:0]  OWriteReg;
    logic        OCRegWrite;
    logic [1:0]  OCMemtoReg;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .IALUResult (IALUResult),
        .IMemWrData (IMemWrData),
        .IWriteReg  (IWriteReg),
        .ICRegWrite (ICRegWrite),
        .ICMemtoReg (ICMemtoReg),
        .ICMemRead  (ICMemRead),
        .ICMemWrite (ICMemWrite),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .mem_fault  (mem_fault),
        .OALUResult (OALUResult),
        .OMemData   (OMemData),
        .OWriteReg  (OWriteReg),
        .OCRegWrite (OCRegWrite),
        .OCMemtoReg (OCMemtoReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic        rw;
        logic [1:0]  mtr;
        logic        rd;
        logic        wr;
        logic        exp_stall;
        logic        exp_fault;
        logic [31:0] exp_alu;
        logic [4:0]  exp_wreg;
        logic        exp_rw;
        logic [1:0]  exp_mtr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wreg,
                          input logic rw, input logic [1:0] mtr, input logic rd, input logic wr);
        IALUResult = alu;
        IMemWrData = wd;
        IWriteReg  = wreg;
        ICRegWrite = rw;
        ICMemtoReg = mtr;
        ICMemRead  = rd;
        ICMemWrite = wr;
    endtask

    task automatic set_idle();
        set_in(32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // Complete aligned access: ack arrives after ack_after BUSY cycles
    // without ack. Leaves inputs idle at the end.
    task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                             input logic is_wr, input logic [4:0] wreg, input logic rw,
                             input int ack_after, input logic [31:0] rd);
        set_in(addr, wd, wreg, rw, 2'd1, !is_wr, is_wr);
        #1;
        chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd1);
        chk({tag, "_req_pre"}, {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, is_wr});
        chk({tag, "_addr"}, mem_addr, addr);
        if (is_wr) chk({tag, "_wdata"}, mem_wdata, wd);
        chk({tag, "_bubble0"}, {31'd0, OCRegWrite}, 32'd0);
        chk({tag, "_fault0"}, {31'd0, mem_fault}, 32'd0);
        for (int i = 0; i < ack_after; i++) begin
            chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
            chk({tag, "_req_hold"}, {31'd0, mem_req}, 32'd1);
            chk({tag, "_addr_hold"}, mem_addr, addr);
            chk({tag, "_we_hold"}, {31'd0, mem_we}, {31'd0, is_wr});
            chk({tag, "_bubble"}, {31'd0, OCRegWrite}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        #1;
        chk({tag, "_stall_ack"}, {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        chk({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_memdata"}, OMemData, is_wr ? 32'd0 : rd);
        chk({tag, "_regwrite"}, {31'd0, OCRegWrite}, {31'd0, rw});
        chk({tag, "_wreg"}, {27'd0, OWriteReg}, {27'd0, wreg});
        chk({tag, "_alu"}, OALUResult, addr);
        chk({tag, "_fault"}, {31'd0, mem_fault}, 32'd0);
        set_idle();
        #1;
        chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
        $display("txn %s addr=0x%08h we=%0b OMemData=0x%08h", tag, addr, is_wr, OMemData);
    endtask

    initial begin
        //            alu           wreg  rw mtr rd wr  stall fault exp_alu       wreg  rw  mtr
        vecs[0] = '{32'h0000_1234, 5'd5,  1, 2'd0, 0, 0, 0, 0, 32'h0000_1234, 5'd5,  1, 2'd0};
        vecs[1] = '{32'hFFFF_0000, 5'd31, 1, 2'd2, 0, 0, 0, 0, 32'hFFFF_0000, 5'd31, 1, 2'd2};
        vecs[2] = '{32'h0000_0102, 5'd7,  1, 2'd1, 1, 0, 0, 1, 32'h0000_0102, 5'd7,  0, 2'd1};
        vecs[3] = '{32'h0000_0000, 5'd0,  0, 2'd3, 0, 0, 0, 0, 32'h0000_0000, 5'd0,  0, 2'd3};
        vecs[4] = '{32'h0000_0203, 5'd4,  1, 2'd0, 0, 1, 0, 1, 32'h0000_0203, 5'd4,  0, 2'd0};
        vecs[5] = '{32'h0000_0001, 5'd9,  1, 2'd1, 1, 1, 0, 1, 32'h0000_0001, 5'd9,  0, 2'd1};
        vecs[6] = '{32'hCAFE_BABE, 5'd12, 1, 2'd2, 0, 0, 0, 0, 32'hCAFE_BABE, 5'd12, 1, 2'd2};

        reset     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("rst_oalu", OALUResult, 32'd0);
        chk("rst_regwrite", {31'd0, OCRegWrite}, 32'd0);
        reset = 1'b0;
        $display("txn reset done");

        // Single-cycle IDLE vectors
        for (int v = 0; v < 7; v++) begin
            set_in(vecs[v].alu, 32'h1111_2222, vecs[v].wreg, vecs[v].rw, vecs[v].mtr,
                   vecs[v].rd, vecs[v].wr);
            #1;
            chk($sformatf("v%0d_stall", v), {31'd0, stall}, {31'd0, vecs[v].exp_stall});
            @(posedge clk); #1;
            chk($sformatf("v%0d_fault", v), {31'd0, mem_fault}, {31'd0, vecs[v].exp_fault});
            chk($sformatf("v%0d_alu", v), OALUResult, vecs[v].exp_alu);
            chk($sformatf("v%0d_wreg", v), {27'd0, OWriteReg}, {27'd0, vecs[v].exp_wreg});
            chk($sformatf("v%0d_regwrite", v), {31'd0, OCRegWrite}, {31'd0, vecs[v].exp_rw});
            chk($sformatf("v%0d_mtr", v), {30'd0, OCMemtoReg}, {30'd0, vecs[v].exp_mtr});
            chk($sformatf("v%0d_memdata", v), OMemData, 32'd0);
            chk($sformatf("v%0d_req", v), {31'd0, mem_req}, 32'd0);
            $display("txn vec %0d alu=0x%08h fault=%0b regwrite=%0b", v, OALUResult, mem_fault, OCRegWrite);
        end
        set_idle();
        @(posedge clk); #1;
        chk("fault_clear", {31'd0, mem_fault}, 32'd0);

        // Load with ack on the 4th BUSY cycle (also the timeout-last cycle:
        // ack must win), store with ack on the 2nd, minimum-latency load.
        do_access("load", 32'h0000_0100, 32'h0, 1'b0, 5'd10, 1'b1, 3, 32'hDEAD_BEEF);
        do_access("store", 32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 5'd0, 1'b1, 1, 32'hFFFF_FFFF);
        do_access("load_min", 32'h0000_0104, 32'h0, 1'b0, 5'd11, 1'b1, 0, 32'h0BAD_F00D);

        // Timeout: no ack for 4 BUSY cycles
        set_in(32'h0000_0300, 32'h0, 5'd9, 1'b1, 2'd1, 1'b1, 1'b0);
        #1;
        chk("to_stall_idle", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("to_req", {31'd0, mem_req}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to_stall_%0d", k), {31'd0, stall}, (k < 3) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            if (k < 3) begin
                chk($sformatf("to_req_%0d", k), {31'd0, mem_req}, 32'd1);
                chk($sformatf("to_fault_%0d", k), {31'd0, mem_fault}, 32'd0);
            end
        end
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_fault", {31'd0, mem_fault}, 32'd1);
        chk("to_regwrite", {31'd0, OCRegWrite}, 32'd0);
        set_in(32'h0000_0077, 32'h0, 5'd3, 1'b1, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("to_fault_pulse", {31'd0, mem_fault}, 32'd0);
        chk("to_after_alu", OALUResult, 32'h0000_0077);
        $display("txn timeout addr=0x00000300");

        // Stray ack in IDLE is ignored
        set_in(32'h0000_0088, 32'h0, 5'd6, 1'b1, 2'd0, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        chk("stray_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        chk("stray_req", {31'd0, mem_req}, 32'd0);
        chk("stray_memdata", OMemData, 32'd0);
        chk("stray_regwrite", {31'd0, OCRegWrite}, 32'd1);
        chk("stray_alu", OALUResult, 32'h0000_0088);
        $display("txn stray ack ignored");
        set_idle();

        // Reset two cycles into BUSY
        set_in(32'h0000_0400, 32'h0, 5'd8, 1'b1, 2'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("rb_req", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rb_we", {31'd0, mem_we}, 32'd0);
        chk("rb_addr", mem_addr, 32'd0);
        chk("rb_wdata", mem_wdata, 32'd0);
        chk("rb_fault", {31'd0, mem_fault}, 32'd0);
        chk("rb_oalu", OALUResult, 32'd0);
        chk("rb_memdata", OMemData, 32'd0);
        chk("rb_wreg", {27'd0, OWriteReg}, 32'd0);
        chk("rb_regwrite", {31'd0, OCRegWrite}, 32'd0);
        chk("rb_mtr", {30'd0, OCMemtoReg}, 32'd0);
        reset = 1'b0;
        $display("txn reset mid-busy");
        do_access("load_post_rst", 32'h0000_0500, 32'h0, 1'b0, 5'd13, 1'b1, 0, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs in the 5-stage pipeline. Issues data-memory reads and writes over a req/ack handshake to a variable-latency data memory, and stalls the upstream pipeline while an access is outstanding. Handles misalignment and timeout faults. Produces the registered MEM/WB bundle for write-back.

Parameters:
TIMEOUT, 64, max BUSY cycles before abort; 0 disables timeout
CNT_W, 8, width of the timeout counter; TIMEOUT must be < 2^CNT_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
IALUResult  in  32  address for loads/stores, or result to pass through
IMemWrData  in  32  store data
IWriteReg  in  5  destination register
ICRegWrite  in  1  register-write enable
ICMemtoReg  in  2  write-back select, passed through
ICMemRead  in  1  load
ICMemWrite  in  1  store
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  32  word address, byte-addressed, bits [1:0] = 0
mem_wdata  out  32  store data
mem_ack  in  1  memory completion, 1-cycle pulse
mem_rdata  in  32  read data, valid with mem_ack
stall  out  1  combinational; upstream stages hold while 1
mem_fault  out  1  registered 1-cycle pulse on misalignment or timeout
OALUResult  out  32  MEM/WB ALU result
OMemData  out  32  MEM/WB load data
OWriteReg  out  5  MEM/WB destination register
OCRegWrite  out  1  MEM/WB register-write enable
OCMemtoReg  out  2  MEM/WB write-back select

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE; mem_req, mem_we, mem_fault, OCRegWrite = 0; mem_addr, mem_wdata, counter, OALUResult, OMemData, OWriteReg, OCMemtoReg = 0.
- access = ICMemRead | ICMemWrite.
  - If both are set, the access is a write.
  - aligned = (IALUResult[1:0] == 0).
- FSM states: IDLE, BUSY.
- IDLE, no access:
  - stall = 0.
  - MEM/WB latches the inputs at the next edge; OMemData = 0.
  - Latency is 1 cycle.
- IDLE, access and aligned:
  - stall = 1.
  - Next edge: go to BUSY; mem_req = 1; mem_we = ICMemWrite; mem_addr = IALUResult; mem_wdata = IMemWrData; counter = 0.
  - MEM/WB receives a bubble (OCRegWrite = 0).
- IDLE, access and misaligned:
  - No request; stall = 0.
  - Next edge: mem_fault = 1 for one cycle; MEM/WB latches the inputs with OCRegWrite forced to 0.
- BUSY:
  - stall = !mem_ack.
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until ack.
  - Each cycle without ack: counter increments; MEM/WB receives a bubble.
- BUSY and mem_ack:
  - stall = 0 in that cycle.
  - Next edge: go to IDLE; mem_req = 0; MEM/WB latches the inputs (still held stable by the stall) with OMemData = mem_rdata.
  - A store writes OMemData = 0 and passes ICRegWrite through.
  - Minimum load/store latency is 2 cycles: req at cycle N+1, ack earliest N+1, OMemData valid at N+2.
- Timeout: in BUSY with TIMEOUT != 0 and counter == TIMEOUT-1 and no ack:
  - stall = 0.
  - Next edge: go to IDLE; mem_req = 0; mem_fault pulses; MEM/WB latches with OCRegWrite = 0.
- Stray acks: mem_ack in IDLE is ignored. An ack arriving after a timeout or reset is ignored.
- Back-to-back accesses: the unit returns to IDLE for at least one cycle between requests, so mem_req deasserts for ≥1 cycle.
- Reset mid-BUSY: at the reset edge, mem_req drops and the FSM goes to IDLE; the outstanding transaction is abandoned.
- stall depends only on state, access, aligned, mem_ack, counter. There is no combinational path from mem_rdata.

Test Plan:
- ALU op: IALUResult=0x1234, IWriteReg=5, ICRegWrite=1, no access -> stall=0; next cycle OALUResult=0x1234, OWriteReg=5, OCRegWrite=1, mem_req never 1.
- Load, addr 0x100, ack 3 cycles after req, rdata=0xDEADBEEF -> stall=1 for 4 cycles; mem_req=1/mem_we=0/mem_addr=0x100 stable; OMemData=0xDEADBEEF, OCRegWrite=1 the cycle after ack; bubbles before.
- Store, addr 0x200, data 0xA5A5A5A5, ack next cycle -> mem_we=1, mem_wdata=0xA5A5A5A5; stall high 2 cycles; no mem_fault.
- Misaligned load, addr 0x102 -> no mem_req, stall=0, mem_fault pulse 1 cycle, OCRegWrite=0.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then mem_fault pulse, OCRegWrite=0, stall released; a later stray ack is ignored.
- Reset asserted 2 cycles into BUSY -> next cycle mem_req=0, all outputs at reset values; a following load proceeds normally.
